// File: rtl/alu_unit.sv
// alu_unit: registered N-bit ALU with carry/overflow/negative/zero flags.
// One operation per enabled cycle. Result and flags appear one edge after
// the inputs are sampled, and they hold while en is low.
module alu_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [2:0]   opcode,
  input  logic [N-1:0] operandA,
  input  logic [N-1:0] operandB,
  output logic [N-1:0] result,
  output logic         C_Flag,
  output logic         O_Flag,
  output logic         N_Flag,
  output logic         Z_Flag
);

  localparam int SHW = $clog2(N);

  localparam logic [2:0] OP_SUB = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  logic [SHW-1:0]      shamt;
  logic [N-1:0]        b_eff;
  logic                cin;
  logic [N:0]          sum_ext;
  logic signed [N-1:0] sra_res;

  logic [N-1:0] result_d, result_q;
  logic         c_d, c_q;
  logic         o_d, o_q;
  logic         n_d, n_q;
  logic         z_d, z_q;

  // Only the low log2(N) bits of B select the shift distance.
  assign shamt = operandB[SHW-1:0];

  // SUB reuses the adder as A + ~B + 1, so its carry-out means "no borrow".
  assign b_eff   = (opcode == OP_SUB) ? ~operandB : operandB;
  assign cin     = (opcode == OP_SUB);
  assign sum_ext = {1'b0, operandA} + {1'b0, b_eff} + {{N{1'b0}}, cin};
  assign sra_res = $signed(operandA) >>> shamt;

  // Next-state result and flags, purely from the current inputs.
  always_comb begin
    result_d = '0;
    c_d      = 1'b0;
    o_d      = 1'b0;
    case (opcode)
      OP_SUB, OP_ADD: begin
        result_d = sum_ext[N-1:0];
        c_d      = sum_ext[N];
        // Signed overflow: both adder inputs share a sign the sum lacks.
        o_d      = (operandA[N-1] == b_eff[N-1]) &&
                   (sum_ext[N-1] != operandA[N-1]);
      end
      OP_AND:  result_d = operandA & operandB;
      OP_OR:   result_d = operandA | operandB;
      OP_XOR:  result_d = operandA ^ operandB;
      OP_SLL:  result_d = operandA << shamt;
      OP_SRL:  result_d = operandA >> shamt;
      OP_SRA:  result_d = sra_res;
      default: result_d = '0;
    endcase
    n_d = result_d[N-1];
    z_d = (result_d == '0);
  end

  // Output register: async clear, capture on en, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      c_q      <= 1'b0;
      o_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
    end else if (en) begin
      result_q <= result_d;
      c_q      <= c_d;
      o_q      <= o_d;
      n_q      <= n_d;
      z_q      <= z_d;
    end
  end

  assign result = result_q;
  assign C_Flag = c_q;
  assign O_Flag = o_q;
  assign N_Flag = n_q;
  assign Z_Flag = z_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed-vector bench for alu_unit (N = 32) with a
// behavioural reference model and a per-cycle compare process.
module tb_alu_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  opcode;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [31:0] result;
  logic        C_Flag, O_Flag, N_Flag, Z_Flag;

  int tests;
  int fails;

  // expected output bundle {result, C, O, N, Z}
  logic [35:0] exp_q;

  alu_unit #(.N(32)) dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode),
    .operandA(operandA), .operandB(operandB),
    .result(result), .C_Flag(C_Flag), .O_Flag(O_Flag),
    .N_Flag(N_Flag), .Z_Flag(Z_Flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integer arithmetic on wide values.
  function automatic logic [35:0] model(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint ua, ub, sa, sb, sd;
    longint lim;
    logic [31:0] r;
    logic signed [31:0] sra;
    logic c, o;
    int sh;
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = 2147483647;
    sh  = int'(b % 32);
    c = 1'b0;
    o = 1'b0;
    r = '0;
    case (op)
      3'd0: begin
        r  = a - b;
        c  = (ua >= ub);
        sd = sa - sb;
        o  = (sd > lim) || (sd < -lim - 1);
      end
      3'd1: begin
        r  = a + b;
        c  = (ua + ub) > 64'hFFFF_FFFF;
        sd = sa + sb;
        o  = (sd > lim) || (sd < -lim - 1);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << sh;
      3'd6: r = a >> sh;
      default: begin
        sra = $signed(a) >>> sh;
        r   = sra;
      end
    endcase
    return {r, c, o, r[31], (r == 32'd0)};
  endfunction

  function automatic logic [35:0] dut_vec();
    return {result, C_Flag, O_Flag, N_Flag, Z_Flag};
  endfunction

  // Expected register: mirrors the observable capture/hold/clear behaviour.
  always @(posedge clk or posedge rst) begin
    if (rst)     exp_q <= '0;
    else if (en) exp_q <= model(opcode, operandA, operandB);
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    tests++;
    if (dut_vec() !== exp_q) begin
      fails++;
      $display("FAIL cycle_cmp t=%0t got res=%h CONZ=%b want res=%h CONZ=%b",
               $time, result, {C_Flag, O_Flag, N_Flag, Z_Flag},
               exp_q[35:4], exp_q[3:0]);
    end
  end

  task automatic check(input string name, input logic [35:0] got,
                       input logic [35:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got res=%h CONZ=%b want res=%h CONZ=%b",
               name, got[35:4], got[3:0], want[35:4], want[3:0]);
    end
  endtask

  // Drive one vector, let it be captured, then check DUT and model
  // against a hand-computed literal.
  task automatic apply(input string name, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic e, input logic [35:0] want);
    @(negedge clk);
    opcode = op; operandA = a; operandB = b; en = e;
    @(posedge clk);
    #1;
    check(name, dut_vec(), want);
    if (e) check({name, "_model"}, model(op, a, b), want);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; en = 1'b0; opcode = 3'd0; operandA = '0; operandB = '0;
    #1;
    check("reset_initial", dut_vec(), 36'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // make outputs nonzero, then assert reset mid-cycle
    apply("pre_reset_add", 3'd1, 32'h1234_0000, 32'h0000_5678, 1'b1,
          {32'h1234_5678, 4'b0000});
    rst = 1'b1;
    #1;
    check("reset_async", dut_vec(), 36'h0);
    en = 1'b1; opcode = 3'd1; operandA = 32'h7; operandB = 32'h9;
    @(posedge clk); #1;
    check("reset_priority", dut_vec(), 36'h0);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_en0", dut_vec(), 36'h0);

    apply("sub_zero",  3'd0, 32'd32, 32'd32, 1'b1, {32'h0, 4'b1001});
    apply("sub_neg",   3'd0, 32'd64, 32'd96, 1'b1, {32'hFFFF_FFE0, 4'b0010});
    apply("add_ovf",   3'd1, 32'h7FFF_FFFF, 32'd1, 1'b1, {32'h8000_0000, 4'b0110});
    apply("add_carry", 3'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, {32'h0, 4'b1001});
    apply("sub_ovf",   3'd0, 32'h8000_0000, 32'd1, 1'b1, {32'h7FFF_FFFF, 4'b1100});
    apply("xor",       3'd4, 32'd1, 32'd2, 1'b1, {32'd3, 4'b0000});
    apply("and",       3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, {32'hF000_F000, 4'b0010});
    apply("or",        3'd3, 32'h0000_00F0, 32'h0000_000F, 1'b1, {32'h0000_00FF, 4'b0000});
    apply("sll31",     3'd5, 32'd1, 32'd31, 1'b1, {32'h8000_0000, 4'b0010});
    apply("sra4",      3'd7, 32'h8000_0000, 32'd4, 1'b1, {32'hF800_0000, 4'b0010});
    apply("srl36",     3'd6, 32'h8000_0000, 32'd36, 1'b1, {32'h0800_0000, 4'b0000});
    apply("sra_pos",   3'd7, 32'h4000_0000, 32'd2, 1'b1, {32'h1000_0000, 4'b0000});
    apply("sll_zero",  3'd5, 32'hA5A5_A5A5, 32'd32, 1'b1, {32'hA5A5_A5A5, 4'b0010});
    apply("and_zero",  3'd2, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, {32'h0, 4'b0001});
    apply("hold_en0",  3'd1, 32'h7FFF_FFFF, 32'd1, 1'b0, {32'h0, 4'b0001});
    apply("hold_en0b", 3'd0, 32'd5, 32'd9, 1'b0, {32'h0, 4'b0001});

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
Registered N-bit integer arithmetic/logic unit for the processor datapath. Each enabled cycle it computes one of eight operations on operandA/operandB selected by a 3-bit opcode. It captures the result and the four status flags (carry, overflow, negative, zero) into output registers on the next rising clock edge. The flags feed the condition/branch logic.

Parameters:
N, 32, datapath width in bits (N >= 4, power of two for shift-amount decode).

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
en  input  1  capture enable; 1 = register new result/flags this edge, 0 = hold
opcode  input  3  operation select
operandA  input  N  first operand
operandB  input  N  second operand / shift amount
result  output  N  registered operation result
C_Flag  output  1  registered carry flag
O_Flag  output  1  registered signed-overflow flag
N_Flag  output  1  registered negative flag
Z_Flag  output  1  registered zero flag

Behaviour:
- Reset: rst high asynchronously forces result = 0 and C_Flag = O_Flag = N_Flag = Z_Flag = 0, regardless of clk. All outputs are held at these values while rst is high. First capture occurs on the first rising clk edge after rst falls with en = 1.
- Latency: 1 cycle. Inputs sampled at a rising edge with en = 1 appear on the outputs right after that edge. With en = 0 all outputs hold.
- Opcode map (all arithmetic modulo 2^N):
  - 000 SUB: A - B, computed as A + ~B + 1.
  - 001 ADD: A + B.
  - 010 AND: A & B.
  - 011 OR: A | B.
  - 100 XOR: A ^ B.
  - 101 SLL: A << B[log2(N)-1:0].
  - 110 SRL: A >> B[log2(N)-1:0], logical, zero fill.
  - 111 SRA: arithmetic right shift by B[log2(N)-1:0], sign fill.
- Shift amount: upper bits of B above log2(N)-1 are ignored. A shift of 0 returns A unchanged.
- C flag:
  - ADD: carry-out of bit N-1.
  - SUB: carry-out of A + ~B + 1, i.e. 1 when A >= B unsigned (no borrow).
  - Logic ops and shifts: 0.
- O flag:
  - ADD: set when A and B have the same sign and the result sign differs.
  - SUB: set when A and B have different signs and the result sign differs from A.
  - All other ops: 0.
- N flag = result[N-1] for every opcode.
- Z flag = 1 exactly when all N result bits are 0, for every opcode.
- The next-state value is purely combinational from the current inputs. There are no internal state or pipeline hazards beyond the output register.
- rst asserted mid-operation discards the pending capture. rst has priority over en.

Test Plan:
- Reset: assert rst with outputs previously nonzero -> result = 0, all flags 0 immediately (before any clk edge); deassert and hold en = 0 -> outputs stay 0.
- SUB zero: A = 32, B = 32, opcode 000, en = 1 -> after 1 edge result = 0, Z = 1, C = 1, N = 0, O = 0.
- SUB negative: A = 64, B = 96, opcode 000 -> result = 0xFFFFFFE0, N = 1, C = 0, Z = 0, O = 0.
- ADD overflow/carry: A = 0x7FFFFFFF, B = 1, opcode 001 -> result = 0x80000000, O = 1, N = 1, C = 0. Then A = 0xFFFFFFFF, B = 1 -> result = 0, C = 1, Z = 1, O = 0.
- Logic/shifts:
  - A = 1, B = 2, opcode 100 (XOR) -> result = 3, all flags 0.
  - SLL of 1 by 31 -> 0x80000000, N = 1.
  - SRA of 0x80000000 by 4 -> 0xF8000000.
  - SRL of 0x80000000 by 36 (amount 4 used) -> 0x08000000.
- Enable hold: apply an ADD with en = 0 -> result and flags keep their prior values.
